// File: rtl/mem_port_pkg.sv
// mem_port_pkg
//   Shared definitions for the memory-side stage: FSM state encoding,
//   default widths and timeout, and a helper that sizes the wait counter.
package mem_port_pkg;

  localparam int ADDR_W_DEF  = 9;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } state_e;

  // Bits needed to hold values 0..limit inclusive.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer
//   Saturating wait-state counter. `start` loads 1 (first wait cycle),
//   `clear` returns it to 0, otherwise a non-zero count advances until it
//   reaches TIMEOUT and holds there.
//   Ports:
//     clk, clr  - clock, asynchronous active-high reset
//     start     - begin counting (count becomes 1)
//     clear     - stop and zero the counter (wins over start)
//     expired   - count == TIMEOUT
module mem_wait_timer
  import mem_port_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (start) begin
      count_d = CNT_W'(1);
    end else if ((count_q != '0) && (count_q != LIMIT)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/mem_port.sv
// mem_port
//   Memory-side stage holding MAR and MDR. Loads them from the bus, and runs
//   a req/ready handshake with a variable-latency RAM for reads (into MDR)
//   and writes (from MDR). A wait timer aborts transactions that never
//   complete.
//   Ports:
//     clk, clr                 - clock, asynchronous active-high reset
//     BusMuxOut                - bus value for MAR/MDR loads
//     MARin, MDRin, Read, Write- load / transaction strobes (ignored when busy)
//     BusMuxInMDR, mem_wdata   - MDR contents
//     mem_addr                 - MAR contents
//     mem_req, mem_we          - RAM request and direction (registered)
//     mem_rdata, mem_ready     - RAM read data and completion
//     busy, done, err          - status: active, completion pulse, timeout pulse
module mem_port
  import mem_port_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] BusMuxInMDR,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic tmr_start;
  logic tmr_clear;
  logic tmr_expired;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .clr     (clr),
    .start   (tmr_start),
    .clear   (tmr_clear),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    tmr_start = 1'b0;
    tmr_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A MAR load in the same cycle as a start is seen by the
        // transaction, because mem_addr is the register output.
        if (MARin) begin
          mar_d = BusMuxOut[ADDR_W-1:0];
        end
        if (MDRin && Read) begin
          // Read has priority; a simultaneous Write is dropped.
          state_d   = ST_RD_WAIT;
          tmr_start = 1'b1;
        end else begin
          if (MDRin) begin
            mdr_d = BusMuxOut;
          end
          if (Write) begin
            state_d   = ST_WR_WAIT;
            tmr_start = 1'b1;
          end
        end
      end

      ST_RD_WAIT, ST_WR_WAIT: begin
        // Ready in the final allowed cycle still counts as success.
        if (mem_ready) begin
          if (state_q == ST_RD_WAIT) begin
            mdr_d = mem_rdata;
          end
          done_d    = 1'b1;
          state_d   = ST_IDLE;
          tmr_clear = 1'b1;
        end else if (tmr_expired) begin
          err_d     = 1'b1;
          state_d   = ST_IDLE;
          tmr_clear = 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        tmr_clear = 1'b1;
      end
    endcase

    // Status outputs are registered copies of the next state so they carry
    // no combinational path from the inputs.
    mem_req_d = (state_d != ST_IDLE);
    busy_d    = (state_d != ST_IDLE);
    mem_we_d  = (state_d == ST_WR_WAIT);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      mar_q     <= '0;
      mdr_q     <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign BusMuxInMDR = mdr_q;
  assign mem_wdata   = mdr_q;
  assign mem_addr    = mar_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

  // MAR only takes the low bus bits; the rest are intentionally unused.
  generate
    if (DATA_W > ADDR_W) begin : g_bus_hi
      logic unused_bus_hi;
      assign unused_bus_hi = ^BusMuxOut[DATA_W-1:ADDR_W];
    end
  endgenerate

endmodule
